// File: rtl/cordic_pkg.sv
// Shared defaults and FSM encoding for the CORDIC request scheduler.
package cordic_pkg;

  localparam int unsigned ZwDefault      = 32;
  localparam int unsigned CwDefault      = 17;
  localparam int unsigned TimeoutDefault = 64;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } state_e;

endpackage

// File: rtl/cordic_sched_if.sv
// Requester and core-side signal bundle for cordic_sched.
// slave is the scheduler's view; master is the view of the requesters plus core.
interface cordic_sched_if
  import cordic_pkg::*;
#(
  parameter int unsigned NumReq = 4,
  parameter int unsigned Zw     = ZwDefault,
  parameter int unsigned Cw     = CwDefault
);

  logic [NumReq-1:0]    req_valid;
  logic [NumReq*Zw-1:0] req_z;
  logic [NumReq-1:0]    req_ready;
  logic [NumReq-1:0]    rsp_valid;
  logic [Cw-1:0]        rsp_cos;
  logic [Cw-1:0]        rsp_sin;
  logic                 rsp_err;
  logic                 core_start;
  logic [Zw-1:0]        core_z;
  logic                 core_done;
  logic [Cw-1:0]        core_cos;
  logic [Cw-1:0]        core_sin;

  modport slave (
    input  req_valid, req_z, core_done, core_cos, core_sin,
    output req_ready, rsp_valid, rsp_cos, rsp_sin, rsp_err, core_start, core_z
  );

  modport master (
    output req_valid, req_z, core_done, core_cos, core_sin,
    input  req_ready, rsp_valid, rsp_cos, rsp_sin, rsp_err, core_start, core_z
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester above ptr_i, wrapping modulo NumReq.
module rr_arbiter #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   idx_o,
  output logic              any_o
);

  logic [IdxW-1:0] pos;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    pos   = '0;
    for (int unsigned k = 1; k <= NumReq; k++) begin
      pos = IdxW'((32'(ptr_i) + k) % NumReq);
      if (!any_o && req_i[pos]) begin
        any_o = 1'b1;
        idx_o = pos;
      end
    end
    gnt_o[idx_o] = any_o;
  end

endmodule

// File: rtl/cordic_sched.sv
// Shares one iterative CORDIC core between NumReq requesters: round-robin accept,
// launch, wait for done or timeout, then strobe the result back to the owner.
module cordic_sched
  import cordic_pkg::*;
#(
  parameter int unsigned NumReq  = 4,
  parameter int unsigned Zw      = ZwDefault,
  parameter int unsigned Cw      = CwDefault,
  parameter int unsigned Timeout = TimeoutDefault,
  parameter int unsigned IdxW    = $clog2(NumReq)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  cordic_sched_if.slave   sched_if,
  output logic            busy_o,
  output logic [IdxW-1:0] grant_id_o
);

  localparam int unsigned   CntW    = (Timeout > 1) ? $clog2(Timeout) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(Timeout - 1);

  state_e          state_q, state_d;
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0] grant_q, grant_d;
  logic [Zw-1:0]   core_z_q, core_z_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [Cw-1:0]   cos_q, cos_d;
  logic [Cw-1:0]   sin_q, sin_d;
  logic            err_q, err_d;

  logic [NumReq-1:0] arb_gnt;
  logic [IdxW-1:0]   arb_idx;
  logic              arb_any;

  rr_arbiter #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_rr_arbiter (
    .req_i (sched_if.req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    core_z_d = core_z_q;
    cnt_d    = cnt_q;
    cos_d    = cos_q;
    sin_d    = sin_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        // The arbiter only grants a valid requester, so a grant is a transfer.
        if (arb_any) begin
          core_z_d = sched_if.req_z[32'(arb_idx)*Zw +: Zw];
          grant_d  = arb_idx;
          state_d  = StStart;
        end
      end
      StStart: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q + 1'b1;
        // A done on the final WAIT cycle takes priority over the abort.
        if (sched_if.core_done) begin
          cos_d   = sched_if.core_cos;
          sin_d   = sched_if.core_sin;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (cnt_q == CntLast) begin
          cos_d   = '0;
          sin_d   = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        rr_ptr_d = grant_q;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      rr_ptr_q <= IdxW'(NumReq - 1);
      grant_q  <= '0;
      core_z_q <= '0;
      cnt_q    <= '0;
      cos_q    <= '0;
      sin_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      core_z_q <= core_z_d;
      cnt_q    <= cnt_d;
      cos_q    <= cos_d;
      sin_q    <= sin_d;
      err_q    <= err_d;
    end
  end

  assign sched_if.req_ready  = (state_q == StIdle) ? arb_gnt : '0;
  assign sched_if.rsp_valid  = (state_q == StResp) ? (NumReq'(1) << grant_q) : '0;
  assign sched_if.core_start = (state_q == StStart);
  assign sched_if.core_z     = core_z_q;
  assign sched_if.rsp_cos    = cos_q;
  assign sched_if.rsp_sin    = sin_q;
  assign sched_if.rsp_err    = err_q;
  assign busy_o              = (state_q != StIdle);
  assign grant_id_o          = grant_q;

endmodule

// File: tb/tb_cordic_sched.sv
// Randomised bench for cordic_sched with a fixed-latency mock core and a
// round-robin/result reference model.
module tb_cordic_sched;

  localparam int N  = 4;
  localparam int Zw = 32;
  localparam int Cw = 17;
  localparam int To = 64;
  localparam int L  = 16;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       busy;
  logic [1:0] grant_id;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int m_ptr    = N - 1;

  cordic_sched_if #(.NumReq(N), .Zw(Zw), .Cw(Cw)) bus ();

  cordic_sched #(
    .NumReq  (N),
    .Zw      (Zw),
    .Cw      (Cw),
    .Timeout (To)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .sched_if   (bus),
    .busy_o     (busy),
    .grant_id_o (grant_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Mock core: done mock_lat cycles after start, cos = z[16:0], sin = -z[16:0].
  int            mock_lat  = L;
  bit            mock_hang = 1'b0;
  logic          spur_done = 1'b0;
  logic          mock_done;
  logic          active;
  int            rem;
  logic [Zw-1:0] mz;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mock_done <= 1'b0;
      active    <= 1'b0;
      rem       <= 0;
      mz        <= '0;
    end else begin
      mock_done <= 1'b0;
      if (bus.core_start) begin
        mz     <= bus.core_z;
        active <= !mock_hang;
        rem    <= mock_lat - 1;
      end else if (active) begin
        if (rem == 1) begin
          mock_done <= 1'b1;
          active    <= 1'b0;
        end
        rem <= rem - 1;
      end
    end
  end

  assign bus.core_done = mock_done | spur_done;
  assign bus.core_cos  = mock_done ? mz[Cw-1:0] : ~mz[Cw-1:0];
  assign bus.core_sin  = mock_done ? -mz[Cw-1:0] : mz[Cw-1:0];

  function automatic int rr_pick(input int ptr, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [Cw-1:0] exp_sin(input logic [Zw-1:0] z);
    logic [Cw-1:0] c;
    c = z[Cw-1:0];
    return ~c + 1'b1;
  endfunction

  task automatic wait_grant(input int max_cyc, output logic [N-1:0] gv, output int t);
    gv = '0;
    t  = 0;
    for (int i = 0; i < max_cyc; i++) begin
      #1;
      if ((bus.req_ready & bus.req_valid) != '0) begin
        gv = bus.req_ready;
        t  = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_rsp(input int max_cyc, output logic [N-1:0] rv, output int n);
    rv = '0;
    n  = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      #1;
      n++;
      if (bus.rsp_valid != '0) begin
        rv = bus.rsp_valid;
        break;
      end
    end
  endtask

  // Raise one request, wait for acceptance, return in the START cycle.
  task automatic launch(input int idx, input logic [Zw-1:0] z, output logic [N-1:0] gv);
    int t;
    bus.req_z[idx*Zw +: Zw] = z;
    bus.req_valid[idx]      = 1'b1;
    wait_grant(100, gv, t);
    @(negedge clk);
    #1;
    bus.req_valid[idx] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_ptr = N - 1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({busy, bus.core_start, bus.rsp_valid, bus.rsp_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_held: busy=%b start=%b rsp=%b err=%b want all 0",
               busy, bus.core_start, bus.rsp_valid, bus.rsp_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_ptr = N - 1;
    #1;
    n_checks++;
    if ({grant_id, bus.req_ready} !== '0) begin
      n_fail++;
      $display("FAIL reset_grant: grant_id=%0d ready=%b want 0", grant_id, bus.req_ready);
    end
    n_checks++;
    if ({bus.core_z, bus.rsp_cos, bus.rsp_sin} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: core_z=%h cos=%h sin=%h want 0",
               bus.core_z, bus.rsp_cos, bus.rsp_sin);
    end
    bus.req_valid = '1;
    #1;
    n_checks++;
    if (bus.req_ready !== (N'(1) << rr_pick(m_ptr, bus.req_valid))) begin
      n_fail++;
      $display("FAIL reset_priority: ready=%b want %b", bus.req_ready,
               N'(1) << rr_pick(m_ptr, bus.req_valid));
    end
    bus.req_valid = '0;
    #1;
    n_checks++;
    if (bus.req_ready !== '0) begin
      n_fail++;
      $display("FAIL reset_ready_idle: ready=%b want 0", bus.req_ready);
    end
  endtask

  task automatic test_single();
    logic [N-1:0] gv, rv;
    int n;
    launch(2, 32'h0000_1234, gv);
    n_checks++;
    if (gv !== 4'b0100) begin
      n_fail++;
      $display("FAIL single_ready: got %b want 0100", gv);
    end
    n_checks++;
    if ({bus.core_start, busy, grant_id, bus.core_z} !== {1'b1, 1'b1, 2'd2, 32'h0000_1234}) begin
      n_fail++;
      $display("FAIL single_start: start=%b busy=%b gid=%0d z=%h want 1 1 2 00001234",
               bus.core_start, busy, grant_id, bus.core_z);
    end
    wait_rsp(40, rv, n);
    n_checks++;
    if (n !== L + 1 || rv !== 4'b0100) begin
      n_fail++;
      $display("FAIL single_rsp: rsp=%b after %0d want 0100 after %0d", rv, n, L + 1);
    end
    n_checks++;
    if ({bus.rsp_cos, bus.rsp_sin, bus.rsp_err} !== {17'h01234, 17'h1EDCC, 1'b0}) begin
      n_fail++;
      $display("FAIL single_data: cos=%h sin=%h err=%b want 01234 1edcc 0",
               bus.rsp_cos, bus.rsp_sin, bus.rsp_err);
    end
    m_ptr = 2;
    @(negedge clk);
    #1;
    n_checks++;
    if ({bus.rsp_valid, busy, bus.rsp_cos} !== {4'b0000, 1'b0, 17'h01234}) begin
      n_fail++;
      $display("FAIL single_after: rsp=%b busy=%b cos=%h want 0000 0 01234",
               bus.rsp_valid, busy, bus.rsp_cos);
    end
  endtask

  task automatic test_round_robin();
    logic [Zw-1:0] z [N];
    logic [N-1:0]  gv, rv, ev;
    int t, t_prev, n, e;
    do_reset();
    for (int i = 0; i < N; i++) begin
      z[i] = $urandom();
      bus.req_z[i*Zw +: Zw] = z[i];
    end
    bus.req_valid = '1;
    t_prev = 0;
    for (int j = 0; j < N + 1; j++) begin
      e  = rr_pick(m_ptr, bus.req_valid);
      ev = N'(1) << e;
      wait_grant(40, gv, t);
      n_checks++;
      if (gv !== ev) begin
        n_fail++;
        $display("FAIL rr_grant[%0d]: got %b want %b", j, gv, ev);
      end
      if (j > 0) begin
        n_checks++;
        if (t - t_prev !== L + 3) begin
          n_fail++;
          $display("FAIL rr_throughput[%0d]: got %0d cycles want %0d", j, t - t_prev, L + 3);
        end
      end
      t_prev = t;
      wait_rsp(40, rv, n);
      n_checks++;
      if (rv !== ev || bus.rsp_cos !== z[e][Cw-1:0] || bus.rsp_sin !== exp_sin(z[e])) begin
        n_fail++;
        $display("FAIL rr_rsp[%0d]: rsp=%b cos=%h sin=%h want %b %h %h", j, rv,
                 bus.rsp_cos, bus.rsp_sin, ev, z[e][Cw-1:0], exp_sin(z[e]));
      end
      m_ptr = e;
    end
    bus.req_valid = '0;
  endtask

  task automatic test_timeout();
    logic [N-1:0]  gv, rv;
    logic [Zw-1:0] z;
    int n;
    mock_hang = 1'b1;
    z = $urandom() | 32'h1;
    launch(1, z, gv);
    n_checks++;
    if (gv !== (N'(1) << rr_pick(m_ptr, 4'b0010)) || bus.core_start !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_launch: gnt=%b start=%b want 0010 1", gv, bus.core_start);
    end
    wait_rsp(To + 10, rv, n);
    n_checks++;
    if (n !== To + 1 || rv !== 4'b0010) begin
      n_fail++;
      $display("FAIL timeout_rsp: rsp=%b after %0d want 0010 after %0d", rv, n, To + 1);
    end
    n_checks++;
    if ({bus.rsp_err, bus.rsp_cos, bus.rsp_sin} !== {1'b1, 34'd0}) begin
      n_fail++;
      $display("FAIL timeout_data: err=%b cos=%h sin=%h want 1 0 0",
               bus.rsp_err, bus.rsp_cos, bus.rsp_sin);
    end
    m_ptr     = 1;
    mock_hang = 1'b0;
    z = $urandom();
    launch(3, z, gv);
    wait_rsp(40, rv, n);
    n_checks++;
    if (n !== L + 1 || rv !== 4'b1000 || bus.rsp_err !== 1'b0 ||
        bus.rsp_cos !== z[Cw-1:0] || bus.rsp_sin !== exp_sin(z)) begin
      n_fail++;
      $display("FAIL timeout_recover: rsp=%b n=%0d err=%b cos=%h sin=%h want 1000 %0d 0 %h %h",
               rv, n, bus.rsp_err, bus.rsp_cos, bus.rsp_sin, L + 1, z[Cw-1:0], exp_sin(z));
    end
    m_ptr = 3;
  endtask

  task automatic test_late_done();
    logic [N-1:0]  gv, rv;
    logic [Zw-1:0] z;
    int n;
    mock_lat = To + 1;
    z = $urandom();
    launch(0, z, gv);
    wait_rsp(To + 10, rv, n);
    n_checks++;
    if (n !== To + 1 || rv !== 4'b0001 || bus.rsp_err !== 1'b1) begin
      n_fail++;
      $display("FAIL one_late: rsp=%b n=%0d err=%b want 0001 %0d 1", rv, n, bus.rsp_err, To + 1);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if ({busy, bus.rsp_valid, bus.rsp_err} !== {1'b0, 4'b0000, 1'b1}) begin
      n_fail++;
      $display("FAIL done_in_resp: busy=%b rsp=%b err=%b want 0 0000 1",
               busy, bus.rsp_valid, bus.rsp_err);
    end
    mock_lat = To;
    z = $urandom() | 32'h1;
    launch(0, z, gv);
    wait_rsp(To + 10, rv, n);
    n_checks++;
    if (n !== To + 1 || rv !== 4'b0001 || bus.rsp_err !== 1'b0 ||
        bus.rsp_cos !== z[Cw-1:0] || bus.rsp_sin !== exp_sin(z)) begin
      n_fail++;
      $display("FAIL last_cycle_done: rsp=%b n=%0d err=%b cos=%h want 0001 %0d 0 %h",
               rv, n, bus.rsp_err, bus.rsp_cos, To + 1, z[Cw-1:0]);
    end
    mock_lat = L;
    m_ptr    = 0;
  endtask

  task automatic test_reset_mid_wait();
    logic [N-1:0]  gv, rv, ev;
    logic [Zw-1:0] z, z0, z1;
    int n, t, cnt;
    z = $urandom() | 32'h1;
    launch(2, z, gv);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, bus.core_start, bus.rsp_valid, bus.rsp_err, grant_id} !== '0) begin
      n_fail++;
      $display("FAIL midreset_ctrl: busy=%b start=%b rsp=%b err=%b gid=%0d want all 0",
               busy, bus.core_start, bus.rsp_valid, bus.rsp_err, grant_id);
    end
    n_checks++;
    if ({bus.core_z, bus.rsp_cos, bus.rsp_sin} !== '0) begin
      n_fail++;
      $display("FAIL midreset_data: z=%h cos=%h sin=%h want 0",
               bus.core_z, bus.rsp_cos, bus.rsp_sin);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_ptr = N - 1;
    cnt   = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #1;
      if (bus.rsp_valid != '0 || busy) cnt++;
    end
    n_checks++;
    if (cnt !== 0) begin
      n_fail++;
      $display("FAIL midreset_quiet: %0d active cycles want 0", cnt);
    end
    z0 = $urandom();
    z1 = $urandom();
    bus.req_z[0 +: Zw]  = z0;
    bus.req_z[Zw +: Zw] = z1;
    bus.req_valid       = 4'b0011;
    ev = N'(1) << rr_pick(m_ptr, bus.req_valid);
    wait_grant(10, gv, t);
    n_checks++;
    if (gv !== ev) begin
      n_fail++;
      $display("FAIL midreset_priority: got %b want %b", gv, ev);
    end
    @(negedge clk);
    #1;
    bus.req_valid = '0;
    wait_rsp(40, rv, n);
    n_checks++;
    if (rv !== ev || bus.rsp_cos !== z0[Cw-1:0]) begin
      n_fail++;
      $display("FAIL midreset_rsp: rsp=%b cos=%h want %b %h", rv, bus.rsp_cos, ev, z0[Cw-1:0]);
    end
    m_ptr = 0;
  endtask

  task automatic test_spurious_withdraw();
    logic [N-1:0]  gv, rv;
    logic [Cw-1:0] cos_h;
    logic [Zw-1:0] z;
    int n, cnt;
    cos_h = bus.rsp_cos;
    @(negedge clk);
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      if (bus.rsp_valid != '0 || busy || bus.core_start) cnt++;
    end
    n_checks++;
    if (cnt !== 0 || bus.rsp_cos !== cos_h || bus.rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL spurious_done: active=%0d cos=%h err=%b want 0 %h 0",
               cnt, bus.rsp_cos, bus.rsp_err, cos_h);
    end
    z = $urandom();
    launch(0, z, gv);
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      #1;
      if (k == 2) begin
        bus.req_z[Zw +: Zw] = $urandom();
        bus.req_valid[1]    = 1'b1;
      end
      if (k == 8) bus.req_valid[1] = 1'b0;
      if (bus.req_ready != '0) cnt++;
    end
    n_checks++;
    if (cnt !== 0) begin
      n_fail++;
      $display("FAIL ready_while_busy: %0d cycles want 0", cnt);
    end
    wait_rsp(40, rv, n);
    n_checks++;
    if (rv !== 4'b0001 || bus.rsp_cos !== z[Cw-1:0]) begin
      n_fail++;
      $display("FAIL withdraw_job: rsp=%b cos=%h want 0001 %h", rv, bus.rsp_cos, z[Cw-1:0]);
    end
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      #1;
      if (bus.req_ready != '0 || busy || bus.rsp_valid != '0) cnt++;
    end
    n_checks++;
    if (cnt !== 0) begin
      n_fail++;
      $display("FAIL withdrawn_grant: %0d active cycles want 0", cnt);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req_valid = '0;
    bus.req_z     = '0;
    rst_n         = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_late_done();
    test_reset_mid_wait();
    test_spurious_withdraw();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cordic_sched.md
Name: cordic_sched

Overview:
- Round-robin scheduler that shares one iterative CORDIC rotation core (17-bit signed cos/sin outputs, 32-bit angle input) between NUM_REQ requesters.
- Accepts one angle at a time, launches the core, and waits for completion or a timeout.
- Routes the result back to the requester that owns it.
- Sits between the angle producers (NCO/mixer channels) and the single cordic core instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ZW, 32, angle width.
- CW, 17, signed cos/sin width.
- TIMEOUT, 64, maximum WAIT cycles before the job is aborted.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- req_valid  in  NUM_REQ  per-requester request valid.
- req_z  in  NUM_REQ*ZW  flattened angles; requester i uses bits [i*ZW +: ZW].
- req_ready  out  NUM_REQ  one-hot accept.
- rsp_valid  out  NUM_REQ  one-hot, one-cycle result strobe.
- rsp_cos  out  CW  signed result cos.
- rsp_sin  out  CW  signed result sin.
- rsp_err  out  1  qualifies rsp_valid; 1 = timeout abort.
- core_start  out  1  one-cycle start pulse to the core.
- core_z  out  ZW  angle to the core, stable from START until the next job.
- core_done  in  1  one-cycle completion pulse from the core.
- core_cos  in  CW  core cos output, valid while core_done = 1.
- core_sin  in  CW  core sin output, valid while core_done = 1.
- busy  out  1  1 in any state except IDLE.
- grant_id  out  $clog2(NUM_REQ)  index of the current or last owner.

Behaviour:
- Reset (reset = 0, asynchronous) values:
  - state = IDLE.
  - All outputs 0.
  - rr_ptr = NUM_REQ-1, so requester 0 has first priority.
  - Timeout counter 0.
- FSM states: IDLE, START, WAIT, RESP.
- IDLE:
  - Winner = first i with req_valid[i], scanning from rr_ptr+1 upward mod NUM_REQ.
  - req_ready[winner] = 1 combinationally, only while in IDLE; all other bits 0.
  - Transfer occurs on the edge where req_valid & req_ready.
  - On transfer: latch req_z slice into core_z, latch winner into grant_id, go to START.
  - No valid request: stay in IDLE.
- START: core_start = 1 for exactly one cycle; clear the counter; go to WAIT.
- WAIT:
  - Counter increments every cycle.
  - core_done = 1: latch core_cos/core_sin into rsp_cos/rsp_sin, rsp_err = 0, go to RESP.
  - Counter reaches TIMEOUT-1 without core_done: rsp_cos = rsp_sin = 0, rsp_err = 1, go to RESP.
  - core_done on that same last cycle wins: normal result, no error.
- RESP:
  - rsp_valid[grant_id] = 1 for one cycle.
  - rsp_cos/rsp_sin/rsp_err hold their values until the next RESP.
  - rr_ptr = grant_id; go to IDLE.
- Latency: transfer edge T → core_start in cycle T+1 → core_done at cycle T+1+L → rsp_valid at T+2+L.
- Throughput: one job per L+3 cycles.
- Requester rules: must hold req_valid and req_z stable until accepted. Deasserting before acceptance is legal and drops the request.
- core_done outside WAIT is ignored. No result is produced and no state change occurs.
- Results are passed through unmodified; no gain compensation or sign change in this block.
- Reset mid-job aborts immediately:
  - No rsp_valid is produced.
  - The core is not signalled; the core shares the same reset.
- Fairness: each of N continuously requesting ports is served once per N jobs.

Decomposition:
- Shared package cordic_pkg holds:
  - ZW and CW defaults.
  - State encoding constants IDLE/START/WAIT/RESP.
  - Default TIMEOUT.
- One sub-module, rr_arbiter:
  - Combinational round-robin pick.
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot grant, encoded index, any.
- The FSM, counter and datapath registers live in cordic_sched.

Test Plan:
- Mock core: fixed latency L = 16; returns cos = z[16:0], sin = -z[16:0].
- Single request:
  - Stimulus: req_valid[2] = 1, z = 32'h0000_1234.
  - Response: req_ready[2] for one cycle; core_start one cycle later; rsp_valid[2] 18 cycles after transfer; rsp_cos = 17'h01234, rsp_sin = -17'sh1234, rsp_err = 0.
- Round-robin:
  - Stimulus: all four requesters hold valid continuously after reset.
  - Response: grant order 0,1,2,3,0; each rsp_valid goes to the matching index with that requester's z.
- Timeout:
  - Stimulus: mock never asserts core_done.
  - Response: rsp_valid exactly TIMEOUT+1 cycles after core_start (TIMEOUT WAIT cycles, then RESP), with rsp_err = 1 and cos = sin = 0; the next request is served normally.
- Late done:
  - Stimulus: core_done arrives on WAIT cycle TIMEOUT-1.
  - Response: normal result, rsp_err = 0.
- Reset mid-WAIT:
  - Stimulus: drive reset = 0 asynchronously (between clock edges).
  - Response: all outputs 0 immediately, state IDLE, no rsp_valid; after release, requester 0 has priority.
- Spurious done and withdrawn request:
  - Stimulus: core_done pulse while in IDLE; requester 1 drops req_valid before acceptance.
  - Response: no response strobes and no grant to requester 1.
